// File: rtl/bin2bcd_signed_if.sv
// bin2bcd_signed_if
//  Groups the init/DONE handshake, the operand and the BCD result of the
//  signed binary-to-BCD converter.
//  Ports (signals):
//   init   start request, sampled on rising clk edge
//   Dato   signed two's-complement value to convert (WIDTH bits)
//   BCD    magnitude digits, digit0 = BCD[3:0] (4*DIGITS bits)
//   SIGN   1 = converted value was negative
//   BUSY   conversion in progress
//   DONE   one-cycle pulse, BCD/SIGN valid
//  Modports: master drives init/Dato, slave (the converter) drives results.
interface bin2bcd_signed_if #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
);
    logic                  init;
    logic [WIDTH-1:0]      Dato;
    logic [4*DIGITS-1:0]   BCD;
    logic                  SIGN;
    logic                  BUSY;
    logic                  DONE;

    modport master (
        output init, Dato,
        input  BCD, SIGN, BUSY, DONE
    );

    modport slave (
        input  init, Dato,
        output BCD, SIGN, BUSY, DONE
    );
endinterface

// File: rtl/bin2bcd_signed.sv
// bin2bcd_signed
//  Sequential signed-binary to BCD converter using shift-add-3 (double
//  dabble). Takes the two's-complement product from the multiplier on an
//  init pulse and produces a sign bit plus DIGITS BCD digits.
//  Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    bin2bcd_signed_if slave modport (init, Dato, BCD, SIGN, BUSY, DONE)
module bin2bcd_signed #(
    parameter int WIDTH  = 32,
    parameter int DIGITS = 10
) (
    input  logic clk,
    input  logic reset,
    bin2bcd_signed_if.slave bus
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, FIN} state_t;

    state_t              state;
    state_t              state_next;
    logic [WIDTH-1:0]    dato_reg;
    logic                sign_reg;
    logic [WIDTH-1:0]    mag;
    logic [BW+WIDTH-1:0] work;
    logic [BW+WIDTH-1:0] work_adj;
    logic [BW+WIDTH-1:0] work_shifted;
    logic [CW-1:0]       count;
    logic [BW-1:0]       bcd_q;
    logic                sign_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (bus.init) state_next = LOAD;
            LOAD:    state_next = SHIFT;
            SHIFT:   if (count == CW'(1)) state_next = FIN;
            FIN:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Two's-complement magnitude taken as unsigned, so the most negative
    // input maps to 2^(WIDTH-1) without overflowing.
    always_comb begin
        mag = dato_reg[WIDTH-1] ? (~dato_reg + WIDTH'(1)) : dato_reg;
    end

    // One double-dabble step: correct every digit >= 5 in parallel, then
    // shift the whole working register left by one.
    always_comb begin
        work_adj = work;
        for (int i = 0; i < DIGITS; i++) begin
            if (work[WIDTH+4*i +: 4] >= 4'd5) begin
                work_adj[WIDTH+4*i +: 4] = work[WIDTH+4*i +: 4] + 4'd3;
            end
        end
        work_shifted = {work_adj[BW+WIDTH-2:0], 1'b0};
    end

    // Results are registered on the final shift edge so that they are
    // already valid during the FIN cycle when DONE is high, and then hold
    // until the next conversion completes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dato_reg <= '0;
            sign_reg <= 1'b0;
            work     <= '0;
            count    <= '0;
            bcd_q    <= '0;
            sign_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.init) begin
                        dato_reg <= bus.Dato;
                    end
                end
                LOAD: begin
                    sign_reg <= dato_reg[WIDTH-1];
                    work     <= {{BW{1'b0}}, mag};
                    count    <= CW'(WIDTH);
                end
                SHIFT: begin
                    work  <= work_shifted;
                    count <= count - CW'(1);
                    if (count == CW'(1)) begin
                        bcd_q  <= work_shifted[BW+WIDTH-1 -: BW];
                        sign_q <= sign_reg;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.BCD  = bcd_q;
    assign bus.SIGN = sign_q;
    assign bus.BUSY = (state == LOAD) || (state == SHIFT);
    assign bus.DONE = (state == FIN);

endmodule

// File: tb/tb_bin2bcd_signed.sv
// tb_bin2bcd_signed
//  Self-checking bench for bin2bcd_signed: directed corner cases plus
//  random operands compared against a decimal-arithmetic reference model.
//  Ports: none (top-level bench).
module tb_bin2bcd_signed;
    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;

    logic clk;
    logic reset;

    int passCount = 0;
    int totalCount = 0;

    logic [4*DIGITS-1:0] lastBcd;
    logic                lastSign;

    bin2bcd_signed_if #(.WIDTH(WIDTH), .DIGITS(DIGITS)) bus ();

    bin2bcd_signed #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Decimal digits from plain division of the absolute value.
    function automatic logic [4*DIGITS-1:0] refBcd(input logic signed [WIDTH-1:0] v);
        longint m;
        logic [4*DIGITS-1:0] r;
        m = longint'(v);
        if (m < 0) m = -m;
        r = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        totalCount++;
        assert (obs === exp) passCount++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Runs one conversion. initEdge > 0 places an extra init pulse so that
    // it is sampled on that edge number (edge 0 samples the real start).
    task automatic applyStimulus(input logic [WIDTH-1:0] val, input logic [4*DIGITS-1:0] expBcd,
                                 input logic expSign, input int initEdge,
                                 input logic [WIDTH-1:0] extraVal, input string tag);
        int n;
        int busyCnt;
        int extraDone;
        @(negedge clk);
        bus.init = 1'b1;
        bus.Dato = val;
        @(posedge clk);
        @(negedge clk);
        bus.init = 1'b0;
        bus.Dato = $urandom;
        n = 0;
        busyCnt = 0;
        while (!bus.DONE && n < 100) begin
            if (bus.BUSY) busyCnt++;
            if (n == 2) begin
                checkOutput({tag, " hold BCD"}, 64'(bus.BCD), 64'(lastBcd));
                checkOutput({tag, " hold SIGN"}, 64'(bus.SIGN), 64'(lastSign));
            end
            if (n + 1 == initEdge) begin
                bus.init = 1'b1;
                bus.Dato = extraVal;
            end else begin
                bus.init = 1'b0;
            end
            @(posedge clk);
            n++;
            @(negedge clk);
        end
        checkOutput({tag, " latency"}, 64'(n), 64'(WIDTH + 1));
        checkOutput({tag, " busy cycles"}, 64'(busyCnt), 64'(WIDTH + 1));
        checkOutput({tag, " BCD"}, 64'(bus.BCD), 64'(expBcd));
        checkOutput({tag, " SIGN"}, 64'(bus.SIGN), 64'(expSign));
        if (n + 1 == initEdge) begin
            bus.init = 1'b1;
            bus.Dato = extraVal;
        end
        @(posedge clk);
        @(negedge clk);
        bus.init = 1'b0;
        checkOutput({tag, " DONE width"}, 64'(bus.DONE), 64'(0));
        if (initEdge > 0) begin
            extraDone = 0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                if (bus.DONE) extraDone++;
            end
            checkOutput({tag, " extra DONE"}, 64'(extraDone), 64'(0));
            checkOutput({tag, " BCD after"}, 64'(bus.BCD), 64'(expBcd));
        end
        lastBcd  = expBcd;
        lastSign = expSign;
    endtask

    initial begin
        logic [WIDTH-1:0] v;
        logic signed [WIDTH-1:0] prod;
        int n;
        int doneSeen;

        reset    = 1'b1;
        bus.init = 1'b0;
        bus.Dato = '0;
        lastBcd  = '0;
        lastSign = 1'b0;
        repeat (2) @(negedge clk);
        checkOutput("reset BCD", 64'(bus.BCD), 64'(0));
        checkOutput("reset SIGN", 64'(bus.SIGN), 64'(0));
        checkOutput("reset BUSY", 64'(bus.BUSY), 64'(0));
        checkOutput("reset DONE", 64'(bus.DONE), 64'(0));
        reset = 1'b0;

        applyStimulus(32'hFFFE7960, 40'h0000100000, 1'b1, -1, '0, "neg100000");
        applyStimulus(32'h00000000, 40'h0000000000, 1'b0, -1, '0, "zero");
        applyStimulus(32'h80000000, 40'h2147483648, 1'b1, -1, '0, "most negative");
        applyStimulus(32'h7FFFFFFF, 40'h2147483647, 1'b0, -1, '0, "most positive");
        applyStimulus(32'd1073741824, 40'h1073741824, 1'b0, 10, 32'd5, "init while busy");
        applyStimulus(32'd4321, 40'h0000004321, 1'b0, WIDTH + 2, 32'd77, "init during FIN");

        // Reset partway through a conversion.
        @(negedge clk);
        bus.init = 1'b1;
        bus.Dato = -32'sd12345;
        @(posedge clk);
        @(negedge clk);
        bus.init = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort BUSY", 64'(bus.BUSY), 64'(0));
        checkOutput("abort BCD", 64'(bus.BCD), 64'(0));
        checkOutput("abort SIGN", 64'(bus.SIGN), 64'(0));
        checkOutput("abort DONE", 64'(bus.DONE), 64'(0));
        repeat (3) @(negedge clk);
        reset = 1'b0;
        doneSeen = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (bus.DONE) doneSeen++;
        end
        checkOutput("abort no DONE", 64'(doneSeen), 64'(0));
        lastBcd  = '0;
        lastSign = 1'b0;
        applyStimulus(32'd999, 40'h0000000999, 1'b0, -1, '0, "after abort");

        // Stand-in for the upstream multiplier: its product arrives with a
        // one-cycle DONE that is wired straight to init.
        prod = 32'(-100) * 32'(1000);
        applyStimulus(prod, 40'h0000100000, 1'b1, -1, '0, "from multiplier");

        for (int i = 0; i < 30; i++) begin
            if (i % 2 == 0) v = $urandom;
            else v = 32'(int'($urandom_range(0, 2000)) - 1000);
            applyStimulus(v, refBcd($signed(v)), v[WIDTH-1], -1, '0, "random");
        end

        n = 0;
        $display("[TB] %0d/%0d checks passed", passCount, totalCount);
        $finish;
    end
endmodule
